// File: rtl/instr_mem_loader_pkg.sv
// =============================================================================
//  Module  : loader_pkg
//  Brief   : Shared state encoding and constants for the instruction loader.
//  Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

package loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RECV  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_WORD = 4;
    localparam int          ADDR_STEP      = 4;

endpackage

`default_nettype wire

// File: rtl/instr_mem_loader_if.sv
// =============================================================================
//  Module  : instr_mem_loader_if
//  Brief   : UART byte stream in, RAM write port out, as seen by the loader.
//  Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

interface instr_mem_loader_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 12,
    parameter int NB_BYTE = 8
);
    logic               i_rx_valid;
    logic [NB_BYTE-1:0] i_rx_byte;
    logic               o_we;
    logic [NB_DATA-1:0] o_data;
    logic [NB_ADDR-1:0] o_addr;

    modport master (input  i_rx_valid, i_rx_byte, output o_we, o_data, o_addr);
    modport slave  (output i_rx_valid, i_rx_byte, input  o_we, o_data, o_addr);
endinterface

`default_nettype wire

// File: rtl/instr_mem_loader_assembler.sv
// =============================================================================
//  Module  : word_assembler
//  Brief   : Packs bytes MSB-first into a word; pulses word_valid on 4th byte.
//  Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

module word_assembler
    import loader_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  wire logic               clk,
    input  wire logic               i_rst,
    input  wire logic               i_clear,
    input  wire logic               i_valid,
    input  wire logic [NB_BYTE-1:0] i_byte,
    output logic      [NB_DATA-1:0] o_word,
    output logic                    o_word_valid,
    output logic      [1:0]         o_count
);

    logic [NB_DATA-1:0] r_shift;
    logic [1:0]         r_cnt;
    logic [NB_DATA-1:0] w_word;
    logic               w_last;

    // The completed word is presented in the same cycle as the 4th byte strobe
    assign w_word       = {r_shift[NB_DATA-NB_BYTE-1:0], i_byte};
    assign w_last       = i_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));
    assign o_word       = w_word;
    assign o_word_valid = w_last;
    assign o_count      = r_cnt;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_cnt   <= '0;
        end else if (i_valid) begin
            r_shift <= w_word;
            r_cnt   <= w_last ? 2'd0 : r_cnt + 2'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// =============================================================================
//  Module  : instr_mem_loader
//  Brief   : Loads a UART byte stream as 32-bit words into the instruction RAM.
//            Optional inter-byte timeout enabled by macro LOADER_TIMEOUT_EN.
//  Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int NB_DATA        = 32,
    parameter int NB_ADDR        = 12,
    parameter int NB_BYTE        = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  wire logic             clk,
    input  wire logic             i_rst,
    input  wire logic             i_start,
    instr_mem_loader_if.master    bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
`ifdef LOADER_TIMEOUT_EN
    output logic                  o_timeout,
`endif
    output logic [NB_ADDR-2:0]    o_word_count
);

    localparam logic [NB_ADDR-1:0] c_addr_last = ~NB_ADDR'(ADDR_STEP - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_we;
    logic [NB_DATA-1:0] r_data;
    logic [NB_ADDR-1:0] r_addr;
    logic [NB_ADDR-2:0] r_word_count;
    logic               r_overflow;

    logic [NB_DATA-1:0] w_word;
    logic               w_word_valid;
    logic [1:0]         w_byte_count;
    logic               w_asm_valid;
    logic               w_asm_clear;
    logic               w_arm;
    logic               w_load;
    logic               w_timeout_hit;

    assign w_asm_valid = bus.i_rx_valid && (r_state == ST_RECV || r_state == ST_WRITE);
    assign w_asm_clear = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_arm       = i_start && w_asm_clear;
    assign w_load      = (r_state == ST_RECV) && w_word_valid;

    word_assembler #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_word_assembler (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_clear      (w_asm_clear),
        .i_valid      (w_asm_valid),
        .i_byte       (bus.i_rx_byte),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_count      (w_byte_count)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int NB_IDLE = $clog2(TIMEOUT_CYCLES + 1);

    logic [NB_IDLE-1:0] r_idle;
    logic               r_timeout;

    // Only a partially assembled word can time out
    assign w_timeout_hit = (r_state == ST_RECV) && (w_byte_count != 2'd0) &&
                           !bus.i_rx_valid && (r_idle == NB_IDLE'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit;
            if (r_state != ST_RECV || w_byte_count == 2'd0 || bus.i_rx_valid)
                r_idle <= '0;
            else
                r_idle <= r_idle + NB_IDLE'(1);
        end
    end

    assign o_timeout = r_timeout;
`else
    logic w_unused_cfg;
    assign w_timeout_hit = 1'b0;
    assign w_unused_cfg  = (TIMEOUT_CYCLES < 0) ^ (^w_byte_count);
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_next = ST_RECV;
            ST_RECV: begin
                if (w_word_valid)       w_state_next = ST_WRITE;
                else if (w_timeout_hit) w_state_next = ST_DONE;
            end
            ST_WRITE: begin
                if (r_data == NB_DATA'(HALT_WORD) || r_addr == c_addr_last)
                    w_state_next = ST_DONE;
                else
                    w_state_next = ST_RECV;
            end
            ST_DONE:  if (i_start) w_state_next = ST_RECV;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_data       <= '0;
            r_addr       <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_we    <= w_load;
            if (w_load)
                r_data <= w_word;
            if (w_arm) begin
                r_addr       <= '0;
                r_word_count <= '0;
                r_overflow   <= 1'b0;
            end else if (r_state == ST_WRITE) begin
                r_word_count <= r_word_count + (NB_ADDR-1)'(1);
                // Address saturates at the top of the RAM instead of wrapping
                if (r_addr == c_addr_last) begin
                    if (r_data != NB_DATA'(HALT_WORD))
                        r_overflow <= 1'b1;
                end else begin
                    r_addr <= r_addr + NB_ADDR'(ADDR_STEP);
                end
            end
        end
    end

    assign bus.o_we     = r_we;
    assign bus.o_data   = r_data;
    assign bus.o_addr   = r_addr;
    assign o_busy       = (r_state == ST_RECV) || (r_state == ST_WRITE);
    assign o_done       = (r_state == ST_DONE);
    assign o_overflow   = r_overflow;
    assign o_word_count = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// =============================================================================
//  Module  : tb_instr_mem_loader
//  Brief   : Self-checking bench: vector table, directed corner cases, random
//            streams against a transaction-level model. Honours LOADER_TIMEOUT_EN.
//  Rev     : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_instr_mem_loader;
    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 4;
    localparam int NB_BYTE = 8;
    localparam int TO      = 16;
    localparam int MAX_WORDS = 2 ** (NB_ADDR - 2);
    localparam int LAST_ADDR = 2 ** NB_ADDR - 4;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy, done, ovf;
    logic [NB_ADDR-2:0] wcnt;
`ifdef LOADER_TIMEOUT_EN
    logic tmo;
`endif

    always #5 clk = ~clk;

    instr_mem_loader_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_BYTE(NB_BYTE)) u_if ();

    instr_mem_loader #(
        .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_BYTE(NB_BYTE), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .i_rst        (rst),
        .i_start      (start),
        .bus          (u_if.master),
        .o_busy       (busy),
        .o_done       (done),
        .o_overflow   (ovf),
`ifdef LOADER_TIMEOUT_EN
        .o_timeout    (tmo),
`endif
        .o_word_count (wcnt)
    );

    typedef struct packed {
        logic [NB_ADDR-1:0] addr;
        logic [31:0]        data;
    } wr_t;

    typedef struct {
        logic [31:0] word;
        int          exp_addr;
        logic        exp_done;
        logic        exp_ovf;
        int          exp_cnt;
    } vec_t;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  inv_err = 0;
    wr_t wr_q[$];

    always @(negedge clk) begin
        if (u_if.o_we) wr_q.push_back({u_if.o_addr, u_if.o_data});
        if (busy && done) inv_err++;
        if (u_if.o_addr[1:0] != 2'b00) inv_err++;
        if (u_if.o_we && !busy) inv_err++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        u_if.i_rx_valid = 1'b1;
        u_if.i_rx_byte  = b;
        tick();
        u_if.i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_writes(input string name, input wr_t exp_q[$]);
        check({name, "_nwr"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            check({name, "_addr"}, 32'(wr_q[i].addr), 32'(exp_q[i].addr));
            check({name, "_data"}, wr_q[i].data, exp_q[i].data);
        end
    endtask

    vec_t        tbl[4];
    wr_t         exp_q[$];
    logic [7:0]  bq[$];
    logic [31:0] acc;
    int          written, nb, nw, tail, seen;
    logic        ended, m_ovf;

    initial begin
        rst = 1'b1; start = 1'b0;
        u_if.i_rx_valid = 1'b0; u_if.i_rx_byte = '0;
        tick(); tick();

        // Reset state, with a byte strobe coinciding with reset
        u_if.i_rx_valid = 1'b1; u_if.i_rx_byte = 8'hAB;
        tick();
        u_if.i_rx_valid = 1'b0;
        rst = 1'b0;
        check("rst_we",   u_if.o_we,   0);
        check("rst_data", u_if.o_data, 0);
        check("rst_addr", u_if.o_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf",  ovf,  0);
        check("rst_wcnt", wcnt, 0);

        // IDLE ignores bytes
        wr_q.delete();
        send_word(32'h1234_5678);
        tick();
        check("idle_nwr",  wr_q.size(), 0);
        check("idle_busy", busy, 0);

        // Table-driven load: basic word, two more, halt at the last address
        tbl[0] = '{32'h2001_0005, 0,  1'b0, 1'b0, 1};
        tbl[1] = '{32'hDEAD_BEEF, 4,  1'b0, 1'b0, 2};
        tbl[2] = '{32'h1234_5678, 8,  1'b0, 1'b0, 3};
        tbl[3] = '{32'hFFFF_FFFF, 12, 1'b1, 1'b0, 4};
        pulse_start();
        check("start_busy", busy, 1);
        for (int v = 0; v < 4; v++) begin
            for (int b = 3; b >= 0; b--) begin
                check("tbl_we_early", u_if.o_we, 0);
                send_byte(tbl[v].word[8*b +: 8]);
                check("tbl_busy", busy, 1);
            end
            check("tbl_we",   u_if.o_we,   1);
            check("tbl_data", u_if.o_data, tbl[v].word);
            check("tbl_addr", u_if.o_addr, tbl[v].exp_addr);
            tick();
            check("tbl_we_off", u_if.o_we, 0);
            check("tbl_done",   done, tbl[v].exp_done);
            check("tbl_ovf",    ovf,  tbl[v].exp_ovf);
            check("tbl_wcnt",   wcnt, tbl[v].exp_cnt);
        end

        // DONE ignores bytes and holds status
        wr_q.delete();
        send_word(32'hCAFE_0001);
        tick();
        check("done_nwr",  wr_q.size(), 0);
        check("done_addr", u_if.o_addr, 12);
        check("done_wcnt", wcnt, 4);

        // Overflow: restart from DONE, five non-halt words back to back
        pulse_start();
        check("restart_addr", u_if.o_addr, 0);
        check("restart_wcnt", wcnt, 0);
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            send_word(32'h0A0B_0C00 + 32'(i));
            if (i < 4) exp_q.push_back({4'(4 * i), 32'h0A0B_0C00 + 32'(i)});
        end
        repeat (3) tick();
        check_writes("ovf", exp_q);
        check("ovf_done", done, 1);
        check("ovf_flag", ovf,  1);
        check("ovf_wcnt", wcnt, 4);
        check("ovf_addr", u_if.o_addr, 12);

        // Back-to-back bytes: the 5th byte lands in the WRITE cycle
        do_reset(); wr_q.delete(); pulse_start();
        for (int i = 0; i < 8; i++) begin
            u_if.i_rx_valid = 1'b1;
            u_if.i_rx_byte  = 8'(8'h11 * (i + 1));
            tick();
        end
        u_if.i_rx_valid = 1'b0;
        repeat (3) tick();
        exp_q.delete();
        exp_q.push_back({4'd0, 32'h1122_3344});
        exp_q.push_back({4'd4, 32'h5566_7788});
        check_writes("b2b", exp_q);
        check("b2b_busy", busy, 1);
        check("b2b_wcnt", wcnt, 2);

        // Halt termination after three words
        do_reset(); wr_q.delete(); pulse_start();
        send_word(32'h0000_0013); send_word(32'h0040_0093); send_word(32'hFFFF_FFFF);
        repeat (3) tick();
        exp_q.delete();
        exp_q.push_back({4'd0, 32'h0000_0013});
        exp_q.push_back({4'd4, 32'h0040_0093});
        exp_q.push_back({4'd8, 32'hFFFF_FFFF});
        check_writes("halt", exp_q);
        check("halt_done", done, 1);
        check("halt_ovf",  ovf,  0);
        check("halt_wcnt", wcnt, 3);

        // Reset mid-word discards the partial word
        do_reset(); wr_q.delete(); pulse_start();
        send_byte(8'hEE); send_byte(8'hDD);
        do_reset();
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_addr", u_if.o_addr, 0);
        check("midrst_data", u_if.o_data, 0);
        pulse_start();
        send_word(32'h0102_0304);
        repeat (3) tick();
        exp_q.delete();
        exp_q.push_back({4'd0, 32'h0102_0304});
        check_writes("midrst", exp_q);

`ifdef LOADER_TIMEOUT_EN
        do_reset(); wr_q.delete(); pulse_start();
        check("tmo_rst", tmo, 0);
        send_byte(8'h5A);
        seen = -1;
        for (int j = 1; j <= 3 * TO && seen < 0; j++) begin
            tick();
            if (tmo) seen = j;
        end
        check("tmo_delay", seen, TO);
        check("tmo_done", done, 1);
        tick();
        check("tmo_pulse", tmo, 0);
        check("tmo_nwr", wr_q.size(), 0);
        check("tmo_ovf", ovf, 0);
`endif

        // Random streams against a transaction-level model
        for (int s = 0; s < 40; s++) begin
            bq.delete(); exp_q.delete();
            nw   = $urandom_range(1, 6);
            tail = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                acc = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom();
                for (int b = 3; b >= 0; b--) bq.push_back(acc[8*b +: 8]);
            end
            for (int t = 0; t < tail; t++) bq.push_back(8'($urandom_range(0, 255)));

            written = 0; nb = 0; ended = 1'b0; m_ovf = 1'b0; acc = '0;
            foreach (bq[i]) begin
                if (!ended) begin
                    acc = (acc << 8) | 32'(bq[i]);
                    nb++;
                    if (nb == 4) begin
                        exp_q.push_back({4'(4 * written), acc});
                        written++;
                        nb = 0;
                        if (acc == 32'hFFFF_FFFF) ended = 1'b1;
                        else if (written == MAX_WORDS) begin ended = 1'b1; m_ovf = 1'b1; end
                    end
                end
            end

            do_reset(); wr_q.delete(); pulse_start();
            foreach (bq[i]) begin
                repeat ($urandom_range(0, 2)) tick();
                send_byte(bq[i]);
            end
            repeat (4) tick();
            check_writes("rnd", exp_q);
            check("rnd_done", done, ended);
            check("rnd_busy", busy, !ended);
            check("rnd_ovf",  ovf,  m_ovf);
            check("rnd_wcnt", wcnt, written);
            check("rnd_addr", u_if.o_addr, (4 * written > LAST_ADDR) ? LAST_ADDR : 4 * written);
        end

        check("invariants", inv_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
